// File: rtl/jpeg_block_sequencer_if.sv
//==============================================================================
// Module      : jpeg_block_sequencer_if
// Description : Handshake and strobe bundle between the block sequencer and
//               the encoder datapath / its controller.
// Revision    : 1.0
//==============================================================================
`default_nettype none

interface jpeg_block_sequencer_if;
    logic        blk_start;
    logic        blk_abort;
    logic        huff_done;
    logic        blk_ready;
    logic        busy;
    logic        input_enable;
    logic        dct_enable;
    logic        dct_end_enable;
    logic [7:0]  matrix_row;
    logic        zigzag_input_enable;
    logic        zigag_enable;
    logic        Huffman_start;
    logic        blk_done;
    logic        err_timeout;
    logic [15:0] blk_count;
    logic [3:0]  state_out;

    modport master (
        output blk_start, blk_abort, huff_done,
        input  blk_ready, busy, input_enable, dct_enable, dct_end_enable,
               matrix_row, zigzag_input_enable, zigag_enable, Huffman_start,
               blk_done, err_timeout, blk_count, state_out
    );

    modport slave (
        input  blk_start, blk_abort, huff_done,
        output blk_ready, busy, input_enable, dct_enable, dct_end_enable,
               matrix_row, zigzag_input_enable, zigag_enable, Huffman_start,
               blk_done, err_timeout, blk_count, state_out
    );
endinterface

`default_nettype wire

// File: rtl/jpeg_block_sequencer.sv
//==============================================================================
// Module      : jpeg_block_sequencer
// Description : Steps one 8x8 block through load, DCT, capture, quantize rows,
//               zigzag scan and Huffman encode, with abort and Huffman timeout.
// Revision    : 1.0
//==============================================================================
`default_nettype none

module jpeg_block_sequencer #(
    parameter int DCT_CYCLES    = 8,
    parameter int DCT_LATENCY   = 2,
    parameter int QUANT_LATENCY = 1,
    parameter int HUFF_TIMEOUT  = 1024
) (
    input  logic                         clock,
    input  logic                         reset,
    jpeg_block_sequencer_if.slave        bus
);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_LOAD      = 4'd1,
        ST_DCT       = 4'd2,
        ST_DCT_WAIT  = 4'd3,
        ST_DCT_CAP   = 4'd4,
        ST_QROW      = 4'd5,
        ST_ZIGZAG    = 4'd6,
        ST_HUFF      = 4'd7,
        ST_HUFF_WAIT = 4'd8,
        ST_DONE      = 4'd9
    } state_e;

    localparam logic [15:0] C_DCT_LAST  = 16'(DCT_CYCLES - 1);
    localparam logic [15:0] C_WAIT_LAST = 16'(DCT_LATENCY - 1);
    localparam logic [15:0] C_SLOT_LAST = 16'(QUANT_LATENCY);
    localparam logic [15:0] C_TIMEOUT   = 16'(HUFF_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  row_q, row_d;
    logic        err_q, err_d;
    logic [15:0] blk_count_q, blk_count_d;

    logic        blk_ready_q, blk_ready_d;
    logic        busy_q, busy_d;
    logic        input_enable_q, input_enable_d;
    logic        dct_enable_q, dct_enable_d;
    logic        dct_end_enable_q, dct_end_enable_d;
    logic [7:0]  matrix_row_q, matrix_row_d;
    logic        zz_in_q, zz_in_d;
    logic        zigag_q, zigag_d;
    logic        huff_start_q, huff_start_d;
    logic        blk_done_q, blk_done_d;
    logic [3:0]  state_out_q, state_out_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        err_d       = err_q;
        blk_count_d = blk_count_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.blk_start) begin
                    state_d = ST_LOAD;
                    err_d   = 1'b0;
                    cnt_d   = 16'd0;
                end
            end
            ST_LOAD: begin
                state_d = ST_DCT;
                cnt_d   = 16'd0;
            end
            ST_DCT: begin
                if (cnt_q == C_DCT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = (DCT_LATENCY == 0) ? ST_DCT_CAP : ST_DCT_WAIT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DCT_WAIT: begin
                if (cnt_q == C_WAIT_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_DCT_CAP;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DCT_CAP: begin
                state_d = ST_QROW;
                row_d   = 3'd0;
                cnt_d   = 16'd0;
            end
            ST_QROW: begin
                // cnt walks the cycles of one row slot; row advances at slot end
                if (cnt_q == C_SLOT_LAST) begin
                    cnt_d = 16'd0;
                    if (row_q == 3'd7) begin
                        row_d   = 3'd0;
                        state_d = ST_ZIGZAG;
                    end else begin
                        row_d = row_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_ZIGZAG: begin
                state_d = ST_HUFF;
            end
            ST_HUFF: begin
                state_d = ST_HUFF_WAIT;
                cnt_d   = 16'd0;
            end
            ST_HUFF_WAIT: begin
                if (bus.huff_done) begin
                    state_d     = ST_DONE;
                    blk_count_d = blk_count_q + 16'd1;
                end else if (cnt_q == C_TIMEOUT) begin
                    state_d     = ST_DONE;
                    err_d       = 1'b1;
                    blk_count_d = blk_count_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.blk_abort && (state_q != ST_IDLE)) begin
            state_d     = ST_IDLE;
            cnt_d       = 16'd0;
            row_d       = 3'd0;
            err_d       = err_q;
            blk_count_d = blk_count_q;
        end

        // Outputs decode the next state so they land in the same register stage
        blk_ready_d      = (state_d == ST_IDLE);
        busy_d           = (state_d != ST_IDLE);
        input_enable_d   = (state_d == ST_LOAD);
        dct_enable_d     = (state_d == ST_DCT);
        dct_end_enable_d = (state_d == ST_DCT_CAP);
        matrix_row_d     = (state_d == ST_QROW) ? {5'd0, row_d} : 8'd0;
        zz_in_d          = (state_d == ST_QROW) && (cnt_d == C_SLOT_LAST);
        zigag_d          = (state_d == ST_ZIGZAG);
        huff_start_d     = (state_d == ST_HUFF);
        blk_done_d       = (state_d == ST_DONE);
        state_out_d      = state_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            cnt_q            <= 16'd0;
            row_q            <= 3'd0;
            err_q            <= 1'b0;
            blk_count_q      <= 16'd0;
            blk_ready_q      <= 1'b1;
            busy_q           <= 1'b0;
            input_enable_q   <= 1'b0;
            dct_enable_q     <= 1'b0;
            dct_end_enable_q <= 1'b0;
            matrix_row_q     <= 8'd0;
            zz_in_q          <= 1'b0;
            zigag_q          <= 1'b0;
            huff_start_q     <= 1'b0;
            blk_done_q       <= 1'b0;
            state_out_q      <= 4'd0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            row_q            <= row_d;
            err_q            <= err_d;
            blk_count_q      <= blk_count_d;
            blk_ready_q      <= blk_ready_d;
            busy_q           <= busy_d;
            input_enable_q   <= input_enable_d;
            dct_enable_q     <= dct_enable_d;
            dct_end_enable_q <= dct_end_enable_d;
            matrix_row_q     <= matrix_row_d;
            zz_in_q          <= zz_in_d;
            zigag_q          <= zigag_d;
            huff_start_q     <= huff_start_d;
            blk_done_q       <= blk_done_d;
            state_out_q      <= state_out_d;
        end
    end

    assign bus.blk_ready           = blk_ready_q;
    assign bus.busy                = busy_q;
    assign bus.input_enable        = input_enable_q;
    assign bus.dct_enable          = dct_enable_q;
    assign bus.dct_end_enable      = dct_end_enable_q;
    assign bus.matrix_row          = matrix_row_q;
    assign bus.zigzag_input_enable = zz_in_q;
    assign bus.zigag_enable        = zigag_q;
    assign bus.Huffman_start       = huff_start_q;
    assign bus.blk_done            = blk_done_q;
    assign bus.err_timeout         = err_q;
    assign bus.blk_count           = blk_count_q;
    assign bus.state_out           = state_out_q;

endmodule

`default_nettype wire
